dproc_wb_ram: RTL and testbench
===============================

DPROC_WB_RAM -- requirements
Module: dproc_wb_ram

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, meaning the RAM size in 32-bit words (power of two, at least 2).
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning the number of cycles from request accept to wb_ack_o (legal 1..4).
REQ-003 The block SHALL have parameter ISSUE_GAP, default 0, meaning the number of forced stall cycles after each accept (legal 0..3).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port wb_adr_i, input, 32 bits: byte address.
REQ-007 The block SHALL have port wb_dat_i, input, 32 bits: write data.
REQ-008 The block SHALL have port wb_dat_o, output, 32 bits: read data.
REQ-009 The block SHALL have port wb_sel_i, input, 4 bits: byte lane enables.
REQ-010 The block SHALL have port wb_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-011 The block SHALL have ports wb_stb_i, input, 1 bit, and wb_cyc_i, input, 1 bit: Wishbone B4 pipelined strobe and cycle.
REQ-012 The block SHALL have ports wb_ack_o, output, 1 bit, and wb_stall_o, output, 1 bit: acknowledge and stall.

Function
REQ-013 Accept SHALL occur on a rising edge with wb_cyc_i & wb_stb_i & !wb_stall_o; exactly one request per accept.
REQ-014 Word index SHALL be wb_adr_i[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing); wb_adr_i[1:0] ignored.
REQ-015 Write SHALL update memory on the accept edge, byte lane n only when wb_sel_i[n]=1; unselected bytes unchanged.
REQ-016 Read SHALL sample the memory word at the accept edge, including writes accepted on earlier edges; all 32 bits returned regardless of wb_sel_i.
REQ-017 wb_ack_o SHALL assert for exactly one cycle, LATENCY cycles after the accept edge, for reads and writes.
REQ-018 wb_dat_o SHALL carry the read word in the ack cycle; in all other cycles, and for write acks, it SHALL be 0.
REQ-019 Acks SHALL return in accept order; back-to-back accepts (ISSUE_GAP=0) SHALL give back-to-back acks, one request per cycle throughput.
REQ-020 The request pipeline SHALL be a LATENCY-deep shift register of {valid, we, data}; no buffering beyond it is needed since it never backpressures.
REQ-021 Gap counter: on accept, load ISSUE_GAP; decrement to 0 otherwise. wb_stall_o = (gap counter != 0) | !rst_i.
REQ-022 wb_stb_i while stalled SHALL be ignored; the master holds the request and it is accepted on the first edge with stall low.
REQ-023 If wb_cyc_i is 0 on an edge, all in-flight pipeline entries SHALL be invalidated (no further acks) and the gap counter cleared; writes already performed remain.
REQ-024 wb_stb_i without wb_cyc_i SHALL be ignored.
REQ-025 No error or retry signalling; every accepted request SHALL be acked unless aborted per REQ-023.

Reset
REQ-026 While rst_i=0 on an edge: pipeline valids cleared, gap counter 0, wb_ack_o=0, wb_dat_o=0; wb_stall_o=1 combinationally while rst_i=0.
REQ-027 Reset SHALL NOT clear memory contents; reset mid-transaction SHALL drop all pending acks.
REQ-028 First accept SHALL be possible on the first edge with rst_i=1.

Verification
REQ-029 LATENCY=1: write 0xDEADBEEF to 0x10 with sel 0xF, then read 0x10 -> acks 1 cycle after each accept, read wb_dat_o=0xDEADBEEF, write-ack wb_dat_o=0.
REQ-030 Byte select: write 0x11223344 to 0x20 (sel 0xF), then 0xAABBCCDD with sel 0x5, read -> 0x11BB33DD.
REQ-031 LATENCY=3, ISSUE_GAP=0: four back-to-back reads of 0x0,0x4,0x8,0xC -> four consecutive ack cycles starting 3 cycles after the first accept, data in order.
REQ-032 ISSUE_GAP=2: stb held high for 8 cycles -> accepts on cycles 0,3,6 only; wb_stall_o high on cycles 1,2,4,5,7.
REQ-033 Abort: LATENCY=4, two reads accepted, wb_cyc_i dropped the next cycle -> no ack issued; a following cycle's read returns correct data.
REQ-034 Reset/aliasing: DEPTH_WORDS=4096, write 0x5A5A5A5A to 0x4000, pulse rst_i low for 2 cycles (stall_o=1, ack_o=0 throughout), read 0x0 -> 0x5A5A5A5A.

Source files
------------

// File: rtl/dproc_wb_ram.sv
// dproc_wb_ram: Wishbone B4 pipelined single-port RAM.
// Fixed ack latency through a shift register of {valid, we, data}; an
// optional issue gap forces stall cycles after every accepted request.
module dproc_wb_ram #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1,
    parameter int ISSUE_GAP   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_stall_o
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]              r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0]       r_vld;
    logic [LATENCY-1:0]       r_we;
    logic [LATENCY-1:0][31:0] r_dat;
    logic [1:0]               r_gap;

    logic                     w_accept;
    logic [AW-1:0]            w_idx;
    logic                     w_ack;
    logic                     w_unused;

    // Upper address bits alias; byte offset is meaningless for word access.
    assign w_idx      = wb_adr_i[AW+1:2];
    assign w_unused   = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    // Stall while a gap is pending, and always while held in reset.
    assign wb_stall_o = (r_gap != 2'd0) | ~rst_i;
    assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;

    // Ack is masked during reset so a pending response never leaks out.
    assign w_ack      = r_vld[LATENCY-1] & rst_i;
    assign wb_ack_o   = w_ack;
    assign wb_dat_o   = (w_ack & ~r_we[LATENCY-1]) ? r_dat[LATENCY-1] : 32'h0;

    // Byte-lane writes on the accept edge; contents are not touched by reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && wb_we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) r_mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    // Valid chain: flushed by reset or by cyc dropping (abort drops acks).
    always_ff @(posedge clk_i) begin
        if (!rst_i || !wb_cyc_i) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    // Payload chain: read word sampled at the accept edge, qualified by valid.
    always_ff @(posedge clk_i) begin
        r_we[0]  <= wb_we_i;
        r_dat[0] <= r_mem[w_idx];
        for (int i = 1; i < LATENCY; i++) begin
            r_we[i]  <= r_we[i-1];
            r_dat[i] <= r_dat[i-1];
        end
    end

    // Issue-gap counter: reload on accept, count down to zero otherwise.
    always_ff @(posedge clk_i) begin
        if (!rst_i || !wb_cyc_i) r_gap <= 2'd0;
        else if (w_accept)       r_gap <= 2'(ISSUE_GAP);
        else if (r_gap != 2'd0)  r_gap <= r_gap - 2'd1;
    end
endmodule

// File: tb/tb_dproc_wb_ram.sv
// tb_dproc_wb_ram: four RAM configurations driven one at a time and
// checked cycle by cycle against a transaction-level reference model.
module tb_dproc_wb_ram;
    localparam int ND = 4;
    localparam int DEP [ND] = '{4096, 64, 32, 16};
    localparam int LAT [ND] = '{1, 3, 4, 2};
    localparam int GAP [ND] = '{0, 0, 0, 2};

    typedef struct packed {
        logic        rst, cyc, stb, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
    } stim_t;

    logic              clk = 1'b0;
    logic [ND-1:0]     rst, cyc, stb, we, ack, stall;
    logic [31:0]       adr [ND], wdat [ND], rdat [ND];
    logic [3:0]        sel [ND];

    int n_vec = 0, n_err = 0, cyc_n = 0;

    // reference model: memory image, ack schedule keyed by due cycle, issue window
    logic [31:0] mm   [ND][4096];
    logic        sv   [ND][8];
    logic        srd  [ND][8];
    logic [31:0] sdat [ND][8];
    int          next_ok [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dproc_wb_ram #(.DEPTH_WORDS(DEP[g]), .LATENCY(LAT[g]), .ISSUE_GAP(GAP[g])) u_dut (
            .clk_i(clk), .rst_i(rst[g]), .wb_adr_i(adr[g]), .wb_dat_i(wdat[g]),
            .wb_dat_o(rdat[g]), .wb_sel_i(sel[g]), .wb_we_i(we[g]), .wb_stb_i(stb[g]),
            .wb_cyc_i(cyc[g]), .wb_ack_o(ack[g]), .wb_stall_o(stall[g]));
    end

    function automatic stim_t mk(input logic r, input logic c, input logic s, input logic w,
                                 input logic [31:0] a, input logic [31:0] dt, input logic [3:0] sl);
        stim_t t;
        t.rst = r; t.cyc = c; t.stb = s; t.we = w; t.adr = a; t.dat = dt; t.sel = sl;
        return t;
    endfunction
    function automatic stim_t wr(input logic [31:0] a, input logic [31:0] dt, input logic [3:0] sl);
        return mk(1'b1, 1'b1, 1'b1, 1'b1, a, dt, sl);
    endfunction
    function automatic stim_t rd(input logic [31:0] a);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, a, 32'h0, 4'h0);
    endfunction
    function automatic stim_t hold();   // cyc kept, no strobe
        return mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endfunction
    function automatic stim_t idle();   // bus released
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endfunction

    function automatic logic e_ack(input int d);
        return rst[d] && sv[d][cyc_n % 8];
    endfunction
    function automatic logic [31:0] e_dat(input int d);
        return (e_ack(d) && srd[d][cyc_n % 8]) ? sdat[d][cyc_n % 8] : 32'h0;
    endfunction
    function automatic logic e_stall(input int d);
        return !rst[d] || (cyc_n < next_ok[d]);
    endfunction

    task automatic drive(input int d, input stim_t s);
        rst[d] = s.rst; cyc[d] = s.cyc; stb[d] = s.stb; we[d] = s.we;
        adr[d] = s.adr; wdat[d] = s.dat; sel[d] = s.sel;
    endtask

    // advance one clock and apply the bus rules to the model at that edge
    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            int idx;
            sv[d][cyc_n % 8] = 1'b0;
            if (!rst[d] || !cyc[d]) begin
                for (int k = 0; k < 8; k++) sv[d][k] = 1'b0;
                next_ok[d] = cyc_n + 1;
            end else if (stb[d] && cyc_n >= next_ok[d]) begin
                idx = int'((adr[d] >> 2) & 32'(DEP[d] - 1));
                sv[d][(cyc_n + LAT[d]) % 8]   = 1'b1;
                srd[d][(cyc_n + LAT[d]) % 8]  = !we[d];
                sdat[d][(cyc_n + LAT[d]) % 8] = mm[d][idx];
                if (we[d])
                    for (int b = 0; b < 4; b++)
                        if (sel[d][b]) mm[d][idx][8*b +: 8] = wdat[d][8*b +: 8];
                next_ok[d] = cyc_n + 1 + GAP[d];
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            for (int d = 0; d < ND; d++) drive(d, mk(1'b0, 1'b1, 1'b1, 1'b0, $urandom, 32'h0, 4'hF));
            #1;
            for (int d = 0; d < ND; d++) begin
                n_vec++; if (stall[d] !== 1'b1) begin n_err++; $display("FAIL reset.stall dut%0d got %b want 1", d, stall[d]); end
                n_vec++; if (ack[d] !== 1'b0) begin n_err++; $display("FAIL reset.ack dut%0d got %b want 0", d, ack[d]); end
                n_vec++; if (rdat[d] !== 32'h0) begin n_err++; $display("FAIL reset.dat dut%0d got %h want 0", d, rdat[d]); end
            end
            tick();
        end
        for (int d = 0; d < ND; d++) drive(d, idle());
    endtask

    task automatic test_write_read();
        stim_t sq[$];
        sq = '{wr(32'h10, 32'hDEADBEEF, 4'hF), rd(32'h10), hold(), idle()};
        foreach (sq[i]) begin
            drive(0, sq[i]); #1;
            n_vec++; if (ack[0] !== e_ack(0)) begin n_err++; $display("FAIL wr_rd.ack cyc %0d got %b want %b", cyc_n, ack[0], e_ack(0)); end
            n_vec++; if (rdat[0] !== e_dat(0)) begin n_err++; $display("FAIL wr_rd.dat cyc %0d got %h want %h", cyc_n, rdat[0], e_dat(0)); end
            n_vec++; if (stall[0] !== e_stall(0)) begin n_err++; $display("FAIL wr_rd.stall cyc %0d got %b want %b", cyc_n, stall[0], e_stall(0)); end
            if (i == 2) begin
                n_vec++; if (rdat[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_rd.const got %h want deadbeef", rdat[0]); end
            end
            tick();
        end
    endtask

    task automatic test_byte_sel();
        stim_t sq[$];
        sq = '{wr(32'h20, 32'h11223344, 4'hF), wr(32'h20, 32'hAABBCCDD, 4'h5), rd(32'h20), hold(), idle()};
        foreach (sq[i]) begin
            drive(0, sq[i]); #1;
            n_vec++; if (ack[0] !== e_ack(0)) begin n_err++; $display("FAIL bytesel.ack cyc %0d got %b want %b", cyc_n, ack[0], e_ack(0)); end
            n_vec++; if (rdat[0] !== e_dat(0)) begin n_err++; $display("FAIL bytesel.dat cyc %0d got %h want %h", cyc_n, rdat[0], e_dat(0)); end
            if (i == 3) begin
                n_vec++; if (rdat[0] !== 32'h11BB33DD) begin n_err++; $display("FAIL bytesel.const got %h want 11bb33dd", rdat[0]); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$];
        sq = '{wr(32'h0, $urandom, 4'hF), wr(32'h4, $urandom, 4'hF), wr(32'h8, $urandom, 4'hF),
               wr(32'hC, $urandom, 4'hF), hold(), rd(32'h0), rd(32'h4), rd(32'h8), rd(32'hC),
               hold(), hold(), hold(), hold(), idle()};
        foreach (sq[i]) begin
            drive(1, sq[i]); #1;
            n_vec++; if (ack[1] !== e_ack(1)) begin n_err++; $display("FAIL b2b.ack cyc %0d got %b want %b", cyc_n, ack[1], e_ack(1)); end
            n_vec++; if (rdat[1] !== e_dat(1)) begin n_err++; $display("FAIL b2b.dat cyc %0d got %h want %h", cyc_n, rdat[1], e_dat(1)); end
            n_vec++; if (stall[1] !== e_stall(1)) begin n_err++; $display("FAIL b2b.stall cyc %0d got %b want %b", cyc_n, stall[1], e_stall(1)); end
            if (i >= 7) begin
                n_vec++; if (ack[1] !== (i >= 8 && i <= 11)) begin n_err++; $display("FAIL b2b.window i %0d got %b want %b", i, ack[1], (i >= 8 && i <= 11)); end
            end
            tick();
        end
    endtask

    task automatic test_gap();
        logic [7:0] pat = 8'b1011_0110;   // stall expected on cycles 1,2,4,5,7
        for (int i = 0; i < 12; i++) begin
            drive(3, (i < 8) ? wr(32'h4, 32'h0BADF00D, 4'hF) : ((i < 11) ? hold() : idle())); #1;
            n_vec++; if (ack[3] !== e_ack(3)) begin n_err++; $display("FAIL gap.ack cyc %0d got %b want %b", cyc_n, ack[3], e_ack(3)); end
            n_vec++; if (stall[3] !== e_stall(3)) begin n_err++; $display("FAIL gap.stall cyc %0d got %b want %b", cyc_n, stall[3], e_stall(3)); end
            if (i < 8) begin
                n_vec++; if (stall[3] !== pat[i]) begin n_err++; $display("FAIL gap.pattern i %0d got %b want %b", i, stall[3], pat[i]); end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        stim_t sq[$];
        int acks = 0;
        sq = '{wr(32'h8, $urandom, 4'hF), wr(32'hC, $urandom, 4'hF), hold(), hold(), hold(), hold(), hold(),
               rd(32'h8), rd(32'hC), idle(), rd(32'hC), hold(), hold(), hold(), hold(), hold(), idle()};
        foreach (sq[i]) begin
            drive(2, sq[i]); #1;
            n_vec++; if (ack[2] !== e_ack(2)) begin n_err++; $display("FAIL abort.ack cyc %0d got %b want %b", cyc_n, ack[2], e_ack(2)); end
            n_vec++; if (rdat[2] !== e_dat(2)) begin n_err++; $display("FAIL abort.dat cyc %0d got %h want %h", cyc_n, rdat[2], e_dat(2)); end
            if (i >= 7 && ack[2] === 1'b1) begin
                acks++;
                n_vec++; if (i != 14) begin n_err++; $display("FAIL abort.when got ack at i %0d want only i 14", i); end
            end
            tick();
        end
        n_vec++; if (acks != 1) begin n_err++; $display("FAIL abort.count got %0d acks want 1", acks); end
    endtask

    task automatic test_reset_alias();
        stim_t sq[$];
        sq = '{wr(32'h4000, 32'h5A5A5A5A, 4'hF), mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0),
               mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0), rd(32'h0), hold(), idle()};
        foreach (sq[i]) begin
            drive(0, sq[i]); #1;
            n_vec++; if (ack[0] !== e_ack(0)) begin n_err++; $display("FAIL rst_alias.ack cyc %0d got %b want %b", cyc_n, ack[0], e_ack(0)); end
            n_vec++; if (rdat[0] !== e_dat(0)) begin n_err++; $display("FAIL rst_alias.dat cyc %0d got %h want %h", cyc_n, rdat[0], e_dat(0)); end
            n_vec++; if (stall[0] !== e_stall(0)) begin n_err++; $display("FAIL rst_alias.stall cyc %0d got %b want %b", cyc_n, stall[0], e_stall(0)); end
            if (i == 4) begin
                n_vec++; if (rdat[0] !== 32'h5A5A5A5A) begin n_err++; $display("FAIL rst_alias.const got %h want 5a5a5a5a", rdat[0]); end
            end
            tick();
        end
    endtask

    task automatic test_random(input int d);
        int aw = $clog2(DEP[d]);
        for (int w = 0; w < 16; w++) begin
            int tries = 0;
            logic done = 1'b0;
            while (!done) begin
                drive(d, wr(($urandom << (aw + 2)) | (32'(w) << 2), $urandom, 4'hF)); #1;
                n_vec++; if (stall[d] !== e_stall(d)) begin n_err++; $display("FAIL rnd.pre.stall dut%0d cyc %0d got %b want %b", d, cyc_n, stall[d], e_stall(d)); end
                done = !e_stall(d);
                tick();
                tries++;
                if (tries > 8 && !done) begin
                    n_err++; $display("FAIL rnd.pre.timeout dut%0d word %0d never accepted", d, w);
                    done = 1'b1;
                end
            end
        end
        for (int i = 0; i < 160; i++) begin
            logic [31:0] a = ($urandom << (aw + 2)) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            drive(d, mk($urandom_range(0, 49) != 0, $urandom_range(0, 19) != 0, $urandom_range(0, 9) < 7,
                        $urandom_range(0, 1) == 1, a, $urandom, 4'($urandom))); #1;
            n_vec++; if (ack[d] !== e_ack(d)) begin n_err++; $display("FAIL rnd.ack dut%0d cyc %0d got %b want %b", d, cyc_n, ack[d], e_ack(d)); end
            n_vec++; if (rdat[d] !== e_dat(d)) begin n_err++; $display("FAIL rnd.dat dut%0d cyc %0d got %h want %h", d, cyc_n, rdat[d], e_dat(d)); end
            n_vec++; if (stall[d] !== e_stall(d)) begin n_err++; $display("FAIL rnd.stall dut%0d cyc %0d got %b want %b", d, cyc_n, stall[d], e_stall(d)); end
            tick();
        end
        drive(d, idle());
        tick();
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            next_ok[d] = 0;
            for (int k = 0; k < 8; k++) begin sv[d][k] = 1'b0; srd[d][k] = 1'b0; sdat[d][k] = 32'h0; end
            for (int k = 0; k < 4096; k++) mm[d][k] = 32'h0;
            drive(d, mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0));
        end
        test_reset();
        test_write_read();
        test_byte_sel();
        test_back_to_back();
        test_gap();
        test_abort();
        test_reset_alias();
        for (int d = 0; d < ND; d++) test_random(d);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
